// File: rtl/mano_pkg.sv
// Shared constants and enums for the two-port memory arbiter.
// The CPU and the loader take turns on one single-ported RAM.
package mano_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] LOCK_MAX = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_LDR
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU port, loader port and shared RAM port.
// The arbiter sits on the slave side; requesters and the RAM sit on the master side.
interface mem_port_arbiter_if;
  import mano_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_wait;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_ack;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_lock;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_wait,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
    output ldr_ack, ldr_rdata,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_wait,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
    input  ldr_ack, ldr_rdata,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/mem_rr_pick.sv
// Two-way owner pick: loader burst lock first, otherwise alternate on a tie.
module mem_rr_pick
  import mano_pkg::*;
(
  input  logic [1:0]       reqs,
  input  owner_t           last_grant,
  input  logic             lock,
  input  logic [CNT_W-1:0] lock_cnt,
  output owner_t           owner
);

  // reqs[0] is the CPU, reqs[1] the loader; an exhausted lock hands the tie to the CPU
  always_comb begin
    owner = OWN_CPU;
    if (reqs[1] && lock && (lock_cnt < LOCK_MAX)) begin
      owner = OWN_LDR;
    end else if (reqs == 2'b11) begin
      if (lock && (lock_cnt >= LOCK_MAX)) begin
        owner = OWN_CPU;
      end else begin
        owner = (last_grant == OWN_CPU) ? OWN_LDR : OWN_CPU;
      end
    end else if (reqs[1]) begin
      owner = OWN_LDR;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one registered RAM port between a CPU and a loader, one access per
// three cycles (IDLE grant, ACCESS drive, DONE ack).
module mem_port_arbiter
  import mano_pkg::*;
(
  input  logic              CLK,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  state_t           state;
  state_t           state_nxt;
  owner_t           owner;
  owner_t           last_grant;
  owner_t           pick;
  logic [CNT_W-1:0] lock_cnt;
  logic             grant;

  mem_rr_pick u_pick (
    .reqs       ({bus.ldr_req, bus.cpu_req}),
    .last_grant (last_grant),
    .lock       (bus.ldr_lock),
    .lock_cnt   (lock_cnt),
    .owner      (pick)
  );

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cpu_req || bus.ldr_req) begin
          state_nxt = ACCESS;
          grant     = 1'b1;
        end
      end
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Requester inputs are only looked at on the grant edge; later changes are ignored
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      bus.ram_addr  <= '0;
      bus.ram_we    <= 1'b0;
      bus.ram_wdata <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.ldr_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.ldr_rdata <= '0;
      owner         <= OWN_CPU;
      last_grant    <= OWN_LDR;
      lock_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.ldr_lock) begin
            lock_cnt <= '0;
          end
          if (grant) begin
            owner      <= pick;
            last_grant <= pick;
            if (pick == OWN_CPU) begin
              bus.ram_addr  <= bus.cpu_addr;
              bus.ram_we    <= bus.cpu_we;
              bus.ram_wdata <= bus.cpu_wdata;
              lock_cnt      <= '0;
            end else begin
              bus.ram_addr  <= bus.ldr_addr;
              bus.ram_we    <= bus.ldr_we;
              bus.ram_wdata <= bus.ldr_wdata;
              if (bus.ldr_lock && (lock_cnt < LOCK_MAX)) begin
                lock_cnt <= lock_cnt + CNT_W'(1);
              end
            end
          end
        end
        ACCESS: begin
          bus.ram_we <= 1'b0;
          if (owner == OWN_CPU) begin
            bus.cpu_rdata <= bus.ram_rdata;
            bus.cpu_ack   <= 1'b1;
          end else begin
            bus.ldr_rdata <= bus.ram_rdata;
            bus.ldr_ack   <= 1'b1;
          end
        end
        DONE: begin
          bus.cpu_ack <= 1'b0;
          bus.ldr_ack <= 1'b0;
        end
        default: begin
          bus.ram_we <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_wait = bus.cpu_req & ~bus.cpu_ack;

endmodule
